// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch controller: issues imem requests, delivers fetched words to
// the IF pipeline register, and handles stalls, branch redirects and the
// draining of requests that were in flight when a redirect arrived.
module if_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        branch_taken,
    input  logic [31:0] branch_addr,
    input  logic        hazard,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] PC_out,
    output logic [31:0] Instruction_out,
    output logic        freeze,
    output logic        flush
);

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    typedef enum logic [1:0] {
        ST_FETCH,
        ST_HOLD,
        ST_DISCARD
    } state_t;

    state_t          state, state_n;
    logic [XLEN-1:0] pc, pc_n;
    logic [XLEN-1:0] req_addr, req_addr_n;
    logic [XLEN-1:0] hold_buf, hold_buf_n;
    logic [XLEN-1:0] pc_plus4;

    // Sequential address increment wraps modulo 2^32 by construction.
    assign pc_plus4 = pc + PC_STEP;

    // State and register update; reset abandons any in-flight request or redirect.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_FETCH;
            pc       <= RESET_PC;
            req_addr <= RESET_PC;
            hold_buf <= '0;
        end else begin
            state    <= state_n;
            pc       <= pc_n;
            req_addr <= req_addr_n;
            hold_buf <= hold_buf_n;
        end
    end

    // Next-state and zero-latency output decisions; branch_taken has top priority.
    always_comb begin
        state_n         = state;
        pc_n            = pc;
        req_addr_n      = req_addr;
        hold_buf_n      = hold_buf;
        imem_req        = 1'b0;
        imem_addr       = pc;
        freeze          = 1'b1;
        flush           = branch_taken;
        PC_out          = pc_plus4;
        Instruction_out = imem_rdata;

        unique case (state)
            ST_FETCH: begin
                imem_req   = 1'b1;
                imem_addr  = pc;
                req_addr_n = pc;
                if (branch_taken) begin
                    // Redirect: a same-cycle response is dropped, otherwise drain it.
                    pc_n = branch_addr;
                    if (!imem_ready) begin
                        state_n = ST_DISCARD;
                    end
                end else if (imem_ready) begin
                    if (hazard) begin
                        hold_buf_n = imem_rdata;
                        state_n    = ST_HOLD;
                    end else begin
                        freeze = 1'b0;
                        pc_n   = pc_plus4;
                    end
                end
            end

            ST_HOLD: begin
                Instruction_out = hold_buf;
                freeze          = hazard | branch_taken;
                if (branch_taken) begin
                    pc_n    = branch_addr;
                    state_n = ST_FETCH;
                end else if (!hazard) begin
                    pc_n    = pc_plus4;
                    state_n = ST_FETCH;
                end
            end

            ST_DISCARD: begin
                // Complete the stale request; its response is never delivered.
                imem_req  = 1'b1;
                imem_addr = req_addr;
                if (branch_taken) begin
                    pc_n = branch_addr;
                end
                if (imem_ready) begin
                    state_n = ST_FETCH;
                end
            end

            default: begin
                state_n = ST_FETCH;
            end
        endcase

        // Reset forces a quiet, frozen interface regardless of other inputs.
        if (rst) begin
            imem_req        = 1'b0;
            imem_addr       = '0;
            freeze          = 1'b1;
            flush           = 1'b0;
            PC_out          = '0;
            Instruction_out = '0;
        end
    end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Self-checking bench for if_fetch_ctrl: directed scenarios followed by random
// stimulus, all compared against a transaction-level reference model.
module tb_if_fetch_ctrl;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic        hazard;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] PC_out;
    logic [31:0] Instruction_out;
    logic        freeze;
    logic        flush;

    int total = 0;
    int bad   = 0;

    // Reference model: next address to fetch, an optional stale request that
    // must still be drained, and a queue holding at most one stalled word.
    logic [31:0] m_pc;
    bit          m_drain;
    logic [31:0] m_drain_addr;
    logic [31:0] m_held[$];
    logic [31:0] delivered[$];

    if_fetch_ctrl #(.RESET_PC(RST_PC)) dut (
        .clk             (clk),
        .rst             (rst),
        .branch_taken    (branch_taken),
        .branch_addr     (branch_addr),
        .hazard          (hazard),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ready      (imem_ready),
        .imem_rdata      (imem_rdata),
        .PC_out          (PC_out),
        .Instruction_out (Instruction_out),
        .freeze          (freeze),
        .flush           (flush)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // One cycle: drive inputs, check outputs against the model, advance the model.
    task automatic step(input bit r, input bit bt, input logic [31:0] ba,
                        input bit hz, input bit rdy, input logic [31:0] rd);
        bit          e_req;
        bit          e_frz;
        logic [31:0] e_addr;
        logic [31:0] e_pco;
        logic [31:0] e_ins;
        bit          chk_data;
        logic [31:0] n_pc;
        bit          n_drain;
        logic [31:0] n_drain_addr;
        bit          n_clear_held;
        bit          n_push_held;

        @(negedge clk);
        rst          = r;
        branch_taken = bt;
        branch_addr  = ba;
        hazard       = hz;
        imem_ready   = rdy;
        imem_rdata   = rd;
        #1;

        e_req = 1'b0; e_frz = 1'b1; e_addr = '0; e_pco = '0; e_ins = '0;
        chk_data = 1'b0;
        n_pc = m_pc; n_drain = m_drain; n_drain_addr = m_drain_addr;
        n_clear_held = 1'b0; n_push_held = 1'b0;

        if (r) begin
            chk_data     = 1'b1;
            n_pc         = RST_PC;
            n_drain      = 1'b0;
            n_clear_held = 1'b1;
        end else if (m_held.size() > 0) begin
            // Stalled word waiting for the pipeline to accept it.
            e_ins    = m_held[0];
            e_pco    = m_pc + 32'd4;
            e_frz    = bt | hz;
            chk_data = 1'b1;
            if (bt) begin
                n_pc = ba; n_clear_held = 1'b1;
            end else if (!hz) begin
                delivered.push_back(m_held[0]);
                n_pc = m_pc + 32'd4; n_clear_held = 1'b1;
            end
        end else if (m_drain) begin
            e_req  = 1'b1;
            e_addr = m_drain_addr;
            if (bt) n_pc = ba;
            if (rdy) n_drain = 1'b0;
        end else begin
            e_req  = 1'b1;
            e_addr = m_pc;
            if (bt) begin
                n_pc = ba;
                if (!rdy) begin
                    n_drain = 1'b1; n_drain_addr = m_pc;
                end
            end else if (rdy && hz) begin
                n_push_held = 1'b1;
            end else if (rdy) begin
                e_frz = 1'b0; e_ins = rd; e_pco = m_pc + 32'd4; chk_data = 1'b1;
                delivered.push_back(rd);
                n_pc = m_pc + 32'd4;
            end
        end

        chk("imem_req", 32'(imem_req), 32'(e_req));
        chk("freeze", 32'(freeze), 32'(e_frz));
        chk("flush", 32'(flush), r ? 32'd0 : 32'(bt));
        if (e_req) chk("imem_addr", imem_addr, e_addr);
        if (chk_data) begin
            chk("PC_out", PC_out, e_pco);
            chk("Instruction_out", Instruction_out, e_ins);
        end

        @(posedge clk);
        m_pc = n_pc; m_drain = n_drain; m_drain_addr = n_drain_addr;
        if (n_clear_held) m_held.delete();
        if (n_push_held) m_held.push_back(rd);
    endtask

    task automatic go(input bit rdy, input logic [31:0] rd);
        step(1'b0, 1'b0, 32'h0, 1'b0, rdy, rd);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b1, 32'h1234_5678, 1'b1, 1'b1, 32'hDEAD_BEEF);
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        logic [31:0] ba;
        rst = 1'b1; branch_taken = 1'b0; branch_addr = '0; hazard = 1'b0;
        imem_ready = 1'b0; imem_rdata = '0;
        m_pc = RST_PC; m_drain = 1'b0; m_drain_addr = RST_PC;

        // Streaming fetch from reset, then a 3-cycle memory wait at 0x10.
        do_reset();
        go(1'b1, 32'hA0); go(1'b1, 32'hA1); go(1'b1, 32'hA2); go(1'b1, 32'hA3);
        go(1'b0, 32'h0); go(1'b0, 32'h0); go(1'b0, 32'h0); go(1'b1, 32'hA4);

        // Hazard holds a fetched word at address 8 for two cycles.
        do_reset();
        go(1'b1, 32'h1); go(1'b1, 32'h2);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'hBEEF);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        go(1'b0, 32'h0);
        go(1'b1, 32'h3);

        // Redirect while 0x20 is pending: drain it, then fetch from 0x100.
        do_reset();
        for (int i = 0; i < 8; i++) go(1'b1, 32'h10 + 32'(i));
        step(1'b0, 1'b1, 32'h100, 1'b0, 1'b0, 32'h0);
        go(1'b0, 32'h0);
        go(1'b1, 32'hBAD0);
        go(1'b1, 32'h55);

        // Redirect with ready and hazard together; then reset inside the drain.
        step(1'b0, 1'b1, 32'h200, 1'b1, 1'b1, 32'hBAD1);
        go(1'b1, 32'h66);
        step(1'b0, 1'b1, 32'h300, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        go(1'b1, 32'h77);

        // Address wrap at the top of the space.
        step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1, 32'h0);
        go(1'b1, 32'h88);
        go(1'b1, 32'h99);

        // Random traffic.
        for (int i = 0; i < 4000; i++) begin
            ba = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
            step($urandom_range(0, 99) == 0,
                 $urandom_range(0, 7) == 0, ba,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 9) < 6,
                 $urandom());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/if_fetch_ctrl.md
IF_FETCH_CTRL -- requirements
Module: if_fetch_ctrl

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 branch_taken  in  1  redirect request from execute stage.
REQ-005 branch_addr  in  32  redirect target; valid while branch_taken=1.
REQ-006 hazard  in  1  downstream stall from hazard unit.
REQ-007 imem_req  out  1  instruction-memory request.
REQ-008 imem_addr  out  32  request address.
REQ-009 imem_ready  in  1  memory response valid this cycle.
REQ-010 imem_rdata  in  32  response word; valid while imem_ready=1.
REQ-011 PC_out  out  32  fetched-instruction address + 4, to IF pipeline register PC_in.
REQ-012 Instruction_out  out  32  fetched word, to IF register Instruction_in.
REQ-013 freeze  out  1  hold IF register.
REQ-014 flush  out  1  clear IF register.

Function
REQ-015 Internal registers SHALL be: pc (32), req_addr (32), buf (32), state {FETCH, HOLD, DISCARD}.
REQ-016 All outputs SHALL be combinational from state, registers and current inputs; zero-latency decisions, single-cycle effect.
REQ-017 flush SHALL equal branch_taken in every state when rst=0; branch_taken has priority over hazard and imem_ready.
REQ-018 FETCH: imem_req=1, imem_addr=pc; req_addr<=pc each cycle.
REQ-019 FETCH, imem_ready=1, branch_taken=0, hazard=0: freeze=0, Instruction_out=imem_rdata, PC_out=pc+4; pc<=pc+4; stay FETCH.
REQ-020 FETCH, imem_ready=1, branch_taken=0, hazard=1: freeze=1; buf<=imem_rdata; go HOLD; pc unchanged.
REQ-021 FETCH, imem_ready=0, branch_taken=0: freeze=1; stay FETCH; imem_req and imem_addr held stable until ready.
REQ-022 FETCH, branch_taken=1, imem_ready=1: response dropped; freeze=1; pc<=branch_addr; stay FETCH.
REQ-023 FETCH, branch_taken=1, imem_ready=0: freeze=1; pc<=branch_addr; go DISCARD.
REQ-024 HOLD: imem_req=0; Instruction_out=buf, PC_out=pc+4; freeze=hazard; on hazard=0 and branch_taken=0, pc<=pc+4, go FETCH.
REQ-025 HOLD, branch_taken=1: buf discarded, freeze=1, pc<=branch_addr, go FETCH.
REQ-026 DISCARD: imem_req=1, imem_addr=req_addr (outstanding request completed, never abandoned); freeze=1; on imem_ready go FETCH, response dropped.
REQ-027 DISCARD, branch_taken=1: pc<=branch_addr (latest target wins); if imem_ready same cycle go FETCH.
REQ-028 pc arithmetic SHALL be modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0.
REQ-029 No instruction SHALL be delivered (freeze=0) in a cycle with branch_taken=1.
REQ-030 When freeze=1, Instruction_out/PC_out are don't-care except as stated in HOLD.

Reset
REQ-031 While rst=1: imem_req=0, freeze=1, flush=0, PC_out=0, Instruction_out=0, regardless of other inputs.
REQ-032 On clock edge with rst=1: pc<=RESET_PC, req_addr<=RESET_PC, buf<=0, state<=FETCH; asserting rst mid-operation (any state) abandons outstanding request and pending branch.
REQ-033 First cycle after rst deasserts: imem_req=1, imem_addr=RESET_PC.

Verification
REQ-034 Reset then imem_ready=1 every cycle, rdata=0xA0,0xA1,0xA2 -> PC_out 4,8,12, freeze=0 each cycle, imem_addr 0,4,8.
REQ-035 imem_ready=0 for 3 cycles at addr 0x10 -> freeze=1 three cycles, imem_addr stays 0x10; ready on 4th -> freeze=0, PC_out=0x14.
REQ-036 Response 0xBEEF at addr 8 with hazard=1 for 2 cycles -> imem_req=0, freeze=1, Instruction_out=0xBEEF held; hazard drops -> freeze=0, next imem_addr=0xC.
REQ-037 branch_taken to 0x100 while addr 0x20 pending, ready 2 cycles later -> flush=1 one cycle, imem_addr stays 0x20 until ready, that word never delivered, next imem_addr=0x100.
REQ-038 branch_taken with imem_ready=1 and hazard=1 same cycle -> flush=1, freeze=1, next imem_addr=branch_addr; rst asserted in DISCARD -> next cycle after release imem_addr=RESET_PC.
